io_stall_ctrl: RTL and testbench

//  Handshake controller between the CPU IO port (io_re/io_we) and the board switches, ENTER key and display.
//  - IO read: stalls the pipeline until the operator presses ENTER, then returns the switch value.
//  - IO write: latches CPU data onto the display and raises a "new output" flag.
//  - Sits in the SOPC beside the CPU; stall_req_o feeds the CPU stall controller.

---
 rtl/io_stall_ctrl_pkg.sv | 33 +++
 rtl/io_stall_ctrl_debounce.sv | 64 ++++++
 rtl/io_stall_ctrl.sv | 83 ++++++++
 tb/tb_io_stall_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/io_stall_ctrl_pkg.sv
// Shared encodings for the IO stall controller: read FSM states, stall levels, bus width.
// No logic; constants and one pure helper only.
// Not applicable.
package io_stall_ctrl_pkg;

  localparam int REG_BUS_W = 32;

  localparam logic [1:0] IO_IDLE       = 2'd0;
  localparam logic [1:0] IO_WAIT_PRESS = 2'd1;
  localparam logic [1:0] IO_DONE       = 2'd2;
  localparam logic [1:0] IO_WAIT_REL   = 2'd3;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  typedef logic [1:0] io_state_t;

  // IDLE and WAIT_REL both pass the request straight through: a fresh read
  // stalls at once, and in WAIT_REL it is parked until the key is released.
  function automatic logic state_stalls(input io_state_t st, input logic io_re);
    logic stall;
    stall = NO_STOP;
    case (st)
      IO_IDLE:       stall = io_re ? STOP : NO_STOP;
      IO_WAIT_PRESS: stall = STOP;
      IO_DONE:       stall = NO_STOP;
      IO_WAIT_REL:   stall = io_re ? STOP : NO_STOP;
      default:       stall = NO_STOP;
    endcase
    return stall;
  endfunction

endpackage

// File: rtl/io_stall_ctrl_debounce.sv
// Key debouncer: 2-flop synchroniser, stability counter, rising-edge press pulse.
// Latency: press_o rises 2 + DB_CYCLES cycles after a clean key edge.
// No flow control; the key is sampled every cycle.
module io_debounce
  import io_stall_ctrl_pkg::*;
#(
  parameter int DB_CYCLES = 16,
  parameter int DB_CNT_W  = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic key_i,
  output logic key_stable_o,
  output logic press_o
);

  logic                key_meta;
  logic                key_sync;
  logic                key_stable;
  logic                key_stable_d;
  logic [DB_CNT_W-1:0] db_cnt;

  localparam logic [DB_CNT_W-1:0] DB_LAST = DB_CNT_W'(DB_CYCLES - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_meta <= 1'b0;
      key_sync <= 1'b0;
    end else begin
      key_meta <= key_i;
      key_sync <= key_meta;
    end
  end

  // Any sample agreeing with the accepted level restarts the count, so
  // only an unbroken run of DB_CYCLES differing samples flips key_stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt     <= '0;
      key_stable <= 1'b0;
    end else if (key_sync != key_stable) begin
      if (db_cnt == DB_LAST) begin
        db_cnt     <= '0;
        key_stable <= ~key_stable;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end else begin
      db_cnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_stable_d <= 1'b0;
    end else begin
      key_stable_d <= key_stable;
    end
  end

  assign key_stable_o = key_stable;
  assign press_o      = key_stable & ~key_stable_d;

endmodule

// File: rtl/io_stall_ctrl.sv
// CPU IO port controller: reads stall until ENTER is pressed, writes latch onto the display.
// Latency: read completes 1 cycle after the debounced press; write visible next cycle.
// Stalls the pipeline combinationally on reads; writes never stall.
module io_stall_ctrl
  import io_stall_ctrl_pkg::*;
#(
  parameter int DW        = REG_BUS_W,
  parameter int DB_CYCLES = 16,
  parameter int DB_CNT_W  = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          io_re_i,
  input  logic          io_we_i,
  input  logic [DW-1:0] io_wdata_i,
  output logic [DW-1:0] io_rdata_o,
  output logic          stall_req_o,
  input  logic          enter_i,
  input  logic [DW-1:0] data_show_i,
  output logic [DW-1:0] data_show_o,
  output logic          out_o
);

  io_state_t state;
  io_state_t state_nxt;
  logic      key_stable;
  logic      press;
  logic      read_hit;
  logic      press_ack;

  io_debounce #(
    .DB_CYCLES (DB_CYCLES),
    .DB_CNT_W  (DB_CNT_W)
  ) u_debounce (
    .clk          (clk),
    .rst          (rst),
    .key_i        (enter_i),
    .key_stable_o (key_stable),
    .press_o      (press)
  );

  assign read_hit  = (state == IO_WAIT_PRESS) && press;
  assign press_ack = press && ((state == IO_WAIT_PRESS) || (state == IO_IDLE));

  always_comb begin
    state_nxt = state;
    case (state)
      IO_IDLE:       if (io_re_i) state_nxt = IO_WAIT_PRESS;
      IO_WAIT_PRESS: if (press) state_nxt = IO_DONE;
      IO_DONE:       state_nxt = IO_WAIT_REL;
      // Waiting for release stops a still-held key from satisfying the next read.
      IO_WAIT_REL:   if (!key_stable) state_nxt = io_re_i ? IO_WAIT_PRESS : IO_IDLE;
      default:       state_nxt = IO_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IO_IDLE;
      io_rdata_o  <= '0;
      data_show_o <= '0;
      out_o       <= 1'b0;
    end else begin
      state <= state_nxt;
      if (read_hit) begin
        io_rdata_o <= data_show_i;
      end
      if (io_we_i) begin
        data_show_o <= io_wdata_i;
      end
      // A new write outranks an acknowledge landing in the same cycle.
      if (io_we_i) begin
        out_o <= 1'b1;
      end else if (press_ack) begin
        out_o <= 1'b0;
      end
    end
  end

  // Reset gates the stall directly so a held io_re_i cannot keep the CPU stalled.
  assign stall_req_o = rst ? NO_STOP : state_stalls(state, io_re_i);

endmodule

// File: tb/tb_io_stall_ctrl.sv
// Directed self-checking bench for io_stall_ctrl with a short debounce window.
module tb_io_stall_ctrl;
  import io_stall_ctrl_pkg::*;

  localparam int DW  = 32;
  localparam int DBC = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          io_re_i = 1'b0;
  logic          io_we_i = 1'b0;
  logic [DW-1:0] io_wdata_i = '0;
  logic [DW-1:0] io_rdata_o;
  logic          stall_req_o;
  logic          enter_i = 1'b0;
  logic [DW-1:0] data_show_i = '0;
  logic [DW-1:0] data_show_o;
  logic          out_o;

  int checks   = 0;
  int failures = 0;
  int press_cnt = 0;
  int p0;

  io_stall_ctrl #(
    .DW        (DW),
    .DB_CYCLES (DBC),
    .DB_CNT_W  (5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .io_re_i     (io_re_i),
    .io_we_i     (io_we_i),
    .io_wdata_i  (io_wdata_i),
    .io_rdata_o  (io_rdata_o),
    .stall_req_o (stall_req_o),
    .enter_i     (enter_i),
    .data_show_i (data_show_i),
    .data_show_o (data_show_o),
    .out_o       (out_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (dut.u_debounce.press_o === 1'b1) press_cnt <= press_cnt + 1;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Clean ENTER edge while in WAIT_PRESS: stalled for 2+DBC cycles, DONE on the next.
  task automatic press_and_read(input string tag, input logic [31:0] exp_data);
    enter_i = 1'b1;
    for (int i = 1; i <= 2 + DBC; i++) begin
      step(1);
      check({tag, "_stall_wait"}, {31'd0, stall_req_o}, 32'd1);
    end
    step(1);
    check({tag, "_stall_done"}, {31'd0, stall_req_o}, 32'd0);
    check({tag, "_rdata"}, io_rdata_o, exp_data);
    check({tag, "_state_done"}, {30'd0, dut.state}, {30'd0, IO_DONE});
  endtask

  initial begin
    // Reset and idle
    step(3);
    rst = 1'b0;
    step(10);
    check("rst_rdata", io_rdata_o, 32'd0);
    check("rst_show", data_show_o, 32'd0);
    check("rst_out", {31'd0, out_o}, 32'd0);
    check("rst_stall", {31'd0, stall_req_o}, 32'd0);

    // First read, key held afterwards
    data_show_i = 32'h0000_00A5;
    io_re_i = 1'b1;
    #1;
    check("rd1_stall_same_cycle", {31'd0, stall_req_o}, 32'd1);
    step(1);
    press_and_read("rd1", 32'h0000_00A5);
    io_re_i = 1'b0;
    step(1);
    check("rd1_wait_rel_stall", {31'd0, stall_req_o}, 32'd0);
    check("rd1_out", {31'd0, out_o}, 32'd0);

    // Second read issued while ENTER is still held
    data_show_i = 32'h0000_003C;
    io_re_i = 1'b1;
    #1;
    check("rd2_stall_held", {31'd0, stall_req_o}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      step(1);
      check("rd2_stall_key_held", {31'd0, stall_req_o}, 32'd1);
    end
    check("rd2_rdata_kept", io_rdata_o, 32'h0000_00A5);
    enter_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      check("rd2_stall_release", {31'd0, stall_req_o}, 32'd1);
    end
    check("rd2_state_wait", {30'd0, dut.state}, {30'd0, IO_WAIT_PRESS});
    press_and_read("rd2", 32'h0000_003C);
    io_re_i = 1'b0;
    enter_i = 1'b0;
    step(10);
    check("rd2_idle_stall", {31'd0, stall_req_o}, 32'd0);
    check("rd2_idle_state", {30'd0, dut.state}, {30'd0, IO_IDLE});

    // Write, then acknowledge by a press in IDLE
    io_we_i = 1'b1;
    io_wdata_i = 32'hDEAD_BEEF;
    #1;
    check("wr_no_stall", {31'd0, stall_req_o}, 32'd0);
    step(1);
    io_we_i = 1'b0;
    check("wr_show", data_show_o, 32'hDEAD_BEEF);
    check("wr_out", {31'd0, out_o}, 32'd1);
    enter_i = 1'b1;
    step(2 + DBC);
    check("ack_out_before", {31'd0, out_o}, 32'd1);
    step(1);
    check("ack_out_cleared", {31'd0, out_o}, 32'd0);
    check("ack_rdata_kept", io_rdata_o, 32'h0000_003C);
    enter_i = 1'b0;
    step(10);

    // Bouncing key gives one press; release gives none
    p0 = press_cnt;
    enter_i = 1'b1;
    step(1);
    enter_i = 1'b0;
    step(1);
    enter_i = 1'b1;
    step(20);
    check("bounce_one_press", press_cnt - p0, 32'd1);
    enter_i = 1'b0;
    step(10);
    check("bounce_release_no_press", press_cnt - p0, 32'd1);

    // Short glitch is rejected
    p0 = press_cnt;
    enter_i = 1'b1;
    step(3);
    enter_i = 1'b0;
    step(15);
    check("glitch_no_press", press_cnt - p0, 32'd0);
    check("glitch_key_stable", {31'd0, dut.u_debounce.key_stable_o}, 32'd0);

    // Write collides with an acknowledging press: write wins
    enter_i = 1'b1;
    step(2 + DBC);
    check("coll_press_now", {31'd0, dut.u_debounce.press_o}, 32'd1);
    io_we_i = 1'b1;
    io_wdata_i = 32'h1234_5678;
    step(1);
    io_we_i = 1'b0;
    check("coll_out", {31'd0, out_o}, 32'd1);
    check("coll_show", data_show_o, 32'h1234_5678);
    enter_i = 1'b0;
    step(10);

    // Read and write in the same cycle
    io_re_i = 1'b1;
    io_we_i = 1'b1;
    io_wdata_i = 32'h0000_55AA;
    data_show_i = 32'h0000_0077;
    #1;
    check("rw_stall", {31'd0, stall_req_o}, 32'd1);
    step(1);
    io_we_i = 1'b0;
    check("rw_show", data_show_o, 32'h0000_55AA);
    check("rw_out", {31'd0, out_o}, 32'd1);
    check("rw_state", {30'd0, dut.state}, {30'd0, IO_WAIT_PRESS});
    press_and_read("rd3", 32'h0000_0077);
    check("rd3_out_cleared", {31'd0, out_o}, 32'd0);
    io_re_i = 1'b0;
    enter_i = 1'b0;
    step(10);

    // Reset during WAIT_PRESS
    io_re_i = 1'b1;
    step(1);
    check("mid_stall", {31'd0, stall_req_o}, 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_stall", {31'd0, stall_req_o}, 32'd0);
    check("mid_rst_rdata", io_rdata_o, 32'd0);
    check("mid_rst_show", data_show_o, 32'd0);
    check("mid_rst_state", {30'd0, dut.state}, {30'd0, IO_IDLE});
    step(2);
    io_re_i = 1'b0;
    rst = 1'b0;
    step(1);
    check("post_rst_state", {30'd0, dut.state}, {30'd0, IO_IDLE});
    check("post_rst_stall", {31'd0, stall_req_o}, 32'd0);
    io_re_i = 1'b1;
    #1;
    check("post_rst_new_read", {31'd0, stall_req_o}, 32'd1);
    step(1);
    check("post_rst_wait_press", {30'd0, dut.state}, {30'd0, IO_WAIT_PRESS});
    io_re_i = 1'b0;
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
